// File: rtl/adder_cla4.sv
// cla4: 4-bit carry-lookahead slice.
//   a[3:0], b[3:0] : operand nibbles (b already conditioned by the caller)
//   ci             : carry into bit 0
//   s[3:0]         : nibble sum
//   co             : carry out of bit 3
//   g, p           : group generate / group propagate for the nibble
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       g,
  output logic       p
);

  logic [3:0] gi;
  logic [3:0] pi;
  logic [3:0] c;

  assign gi = a & b;
  assign pi = a ^ b;

  // Each carry is expanded from ci directly rather than rippled bit to bit.
  assign c[0] = ci;
  assign c[1] = gi[0] | (pi[0] & ci);
  assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
  assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
              | (pi[2] & pi[1] & pi[0] & ci);

  assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
           | (pi[3] & pi[2] & pi[1] & gi[0]);
  assign p = &pi;

  assign s  = pi ^ c;
  assign co = g | (p & ci);

endmodule

// File: rtl/adder.sv
// adder: add/subtract unit with combinational outputs and a registered copy.
//   clk, rst_n : clock and asynchronous active-low reset of the result register
//   a, b       : operands, InputSize bits
//   sub        : 0 -> a+b, 1 -> a-b (a + ~b + 1)
//   en         : capture enable for the result register
//   s, c_o     : combinational result and carry-out (c_o=1 means no borrow on sub)
//   ovf        : combinational signed overflow
//   s_q, c_o_q, ovf_q, zero_q : registered s, c_o, ovf and (s == 0)
module adder #(
  parameter int InputSize = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [InputSize-1:0] a,
  input  logic [InputSize-1:0] b,
  input  logic                 sub,
  input  logic                 en,
  output logic [InputSize-1:0] s,
  output logic                 c_o,
  output logic                 ovf,
  output logic [InputSize-1:0] s_q,
  output logic                 c_o_q,
  output logic                 ovf_q,
  output logic                 zero_q
);

  localparam int NumGroups = InputSize / 4;

  // Subtraction reuses the adder: invert b and feed sub in as the carry-in.
  logic [InputSize-1:0] b_x;
  logic [NumGroups:0]   c;
  logic [NumGroups-1:0] grp_g;
  logic [NumGroups-1:0] grp_p;

  assign b_x  = b ^ {InputSize{sub}};
  assign c[0] = sub;

  for (genvar i = 0; i < NumGroups; i++) begin : g_grp
    cla4 u_cla4 (
      .a  (a[4*i +: 4]),
      .b  (b_x[4*i +: 4]),
      .ci (c[i]),
      .s  (s[4*i +: 4]),
      .co (c[i+1]),
      .g  (grp_g[i]),
      .p  (grp_p[i])
    );
  end

  // Groups are chained by their own carry-out; group g/p are not needed here.
  logic unused_grp_gp;
  assign unused_grp_gp = ^{grp_g, grp_p};

  assign c_o = c[NumGroups];

  // Carry into the MSB is recovered from the MSB sum: s = a ^ b_x ^ cin.
  logic c_msb;
  assign c_msb = s[InputSize-1] ^ a[InputSize-1] ^ b_x[InputSize-1];
  assign ovf   = c_msb ^ c_o;

  logic [InputSize-1:0] s_d;
  logic                 c_o_d;
  logic                 ovf_d;
  logic                 zero_d;

  assign s_d    = s;
  assign c_o_d  = c_o;
  assign ovf_d  = ovf;
  assign zero_d = ~|s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      c_o_q  <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (en) begin
      s_q    <= s_d;
      c_o_q  <= c_o_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

endmodule

// File: tb/tb_adder.sv
module tb_adder;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         en;
  logic [W-1:0] s;
  logic         c_o;
  logic         ovf;
  logic [W-1:0] s_q;
  logic         c_o_q;
  logic         ovf_q;
  logic         zero_q;

  adder #(.InputSize(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .sub    (sub),
    .en     (en),
    .s      (s),
    .c_o    (c_o),
    .ovf    (ovf),
    .s_q    (s_q),
    .c_o_q  (c_o_q),
    .ovf_q  (ovf_q),
    .zero_q (zero_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard: {zero, ovf, c_o, s} expected in the register
  logic [W+2:0] exp_q[$];
  logic [W+2:0] reg_exp;

  task automatic check(input string tag, input logic [W+2:0] obs, input logic [W+2:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Reference: unsigned arithmetic for result/carry, sign rules for overflow.
  function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic msub);
    logic [W-1:0] r;
    logic         cy;
    logic         ov;
    if (!msub) begin
      {cy, r} = {1'b0, ma} + {1'b0, mb};
      ov = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
    end else begin
      r  = ma - mb;
      cy = (ma >= mb);
      ov = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
    end
    return {(r == '0), ov, cy, r};
  endfunction

  // driver: apply at posedge+2, check 10 ns later (posedge+2 of next cycle)
  task automatic run_vec(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic ts, input logic te, input string tag);
    logic [W+2:0] m;
    a = ta; b = tb_v; sub = ts; en = te;
    m = model(ta, tb_v, ts);
    if (te) exp_q.push_back(m);
    #10;
    check({tag, "_s"},   {3'b0, s},   {3'b0, m[W-1:0]});
    check({tag, "_c"},   {66'b0, c_o}, {66'b0, m[W]});
    check({tag, "_ovf"}, {66'b0, ovf}, {66'b0, m[W+1]});
    if (exp_q.size() > 0) reg_exp = exp_q.pop_front();
    check({tag, "_reg"}, {zero_q, ovf_q, c_o_q, s_q}, reg_exp);
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = {1'b0, {(W-1){1'b1}}};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; sub = 1'b1; a = '0; b = '0;
    reg_exp = '0;
    #7;
    // reset state; combinational path live during reset
    check("rst_reg", {zero_q, ovf_q, c_o_q, s_q}, '0);
    check("rst_s",   {3'b0, s},    '0);
    check("rst_c",   {66'b0, c_o}, 67'd1);
    #1 rst_n = 1'b1;
    @(posedge clk); #2;

    // no capture until en=1 after reset
    run_vec(64'd9, 64'd4, 1'b0, 1'b0, "noen");
    run_vec(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, "r029");
    check("r029_lit", {zero_q, ovf_q, c_o_q, s_q}, {3'b101, 64'd0});
    run_vec(64'd5, 64'd3, 1'b1, 1'b1, "r030a");
    check("r030a_lit", {c_o_q, s_q}, {1'b1, 64'd2});
    run_vec(64'd3, 64'd5, 1'b1, 1'b1, "r030b");
    check("r030b_lit", {c_o_q, s_q}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    run_vec(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, "r031");
    check("r031_lit", {ovf_q, c_o_q, s_q}, {2'b10, 64'h8000_0000_0000_0000});
    run_vec(64'd0, 64'd0, 1'b1, 1'b1, "r032");
    check("r032_lit", {zero_q, c_o_q, s_q}, {2'b11, 64'd0});
    // hold with en=0
    run_vec(64'd123, 64'd456, 1'b0, 1'b0, "hold");

    // mid-run asynchronous reset, away from the clock edge
    run_vec(64'hDEAD_BEEF_0000_0001, 64'h1, 1'b0, 1'b1, "pre_rst");
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_reg", {zero_q, ovf_q, c_o_q, s_q}, '0);
    check("mid_rst_s", {3'b0, s}, {3'b0, 64'hDEAD_BEEF_0000_0002});
    en = 1'b0;
    reg_exp = '0;
    exp_q.delete();
    #1 rst_n = 1'b1;
    @(posedge clk); #2;
    run_vec(64'd1, 64'd1, 1'b0, 1'b0, "post_rst_noen");
    run_vec(64'd1, 64'd1, 1'b0, 1'b1, "post_rst_en");

    // randomized
    for (int i = 0; i < 1000; i++)
      run_vec(rand_op(), rand_op(), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) != 0), "rnd");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
